// File: rtl/result_drain_ctrl_if.sv
// Result drain bundle: start/abort request, SRAM read port,
// host output stream and status. master = drain controller.
interface result_drain_ctrl_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int WORD_BW        = PARTIAL_SUM_BW * MATRIX_SIZE
);
  logic                   start;
  logic                   abort;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [ADDRESSSIZE:0]   num_words;
  logic                   sram_rd_en;
  logic [ADDRESSSIZE-1:0] sram_rd_addr;
  logic [WORD_BW-1:0]     sram_rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_BW-1:0]     out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  modport master (
    input  start,
    input  abort,
    input  base_addr,
    input  num_words,
    input  sram_rd_data,
    input  out_ready,
    output sram_rd_en,
    output sram_rd_addr,
    output out_valid,
    output out_data,
    output out_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output base_addr,
    output num_words,
    output sram_rd_data,
    output out_ready,
    input  sram_rd_en,
    input  sram_rd_addr,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy,
    input  done
  );
endinterface

// File: rtl/result_drain_ctrl.sv
// Result SRAM drain: reads num_words from base_addr and streams
// them to the host through a 2-entry skid buffer.
// Ports: clk, rst (sync, active-high), bus (master modport):
//   start/abort/base_addr/num_words request, sram_rd_* read port,
//   out_valid/out_ready/out_data/out_last stream, busy/done status.
module result_drain_ctrl #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int WORD_BW        = PARTIAL_SUM_BW * MATRIX_SIZE
) (
  input logic                 clk,
  input logic                 rst,
  result_drain_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FINISH
  } state_e;

  localparam int AW = ADDRESSSIZE;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     num_q, num_d;
  logic [AW:0]     issued_q, issued_d;
  logic [AW:0]     sent_q, sent_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [WORD_BW-1:0] mem_q [2];

  logic          active;
  logic          valid;
  logic          pop;
  logic          push;
  logic          credit_ok;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          last_hit;

  assign active = (state_q == S_ACTIVE);
  assign valid  = (cnt_q != 2'd0);
  assign pop    = valid & bus.out_ready;

  // Credit: words buffered plus the read in flight, less the
  // word leaving this cycle, must leave room for one more.
  assign credit_ok =
    ({1'b0, cnt_q} + {2'b00, inflight_q})
      < (3'd2 + {2'b00, pop});

  assign rd_en = active
               & (issued_q < num_q)
               & credit_ok
               & ~bus.abort;

  // Address wraps naturally at the SRAM size.
  assign rd_addr = base_q + issued_q[AW-1:0];

  // A return landing during abort is discarded with the buffer.
  assign push = inflight_q & active & ~bus.abort;

  assign last_hit = (sent_q == (num_q - 1'b1));

  assign bus.sram_rd_en   = rd_en;
  assign bus.sram_rd_addr = rd_en ? rd_addr : addr_q;
  assign bus.out_valid    = valid;
  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.out_last     = valid & last_hit;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_FINISH);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = rd_en;
    addr_d     = rd_en ? rd_addr : addr_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d   = bus.base_addr;
          num_d    = bus.num_words;
          issued_d = '0;
          sent_d   = '0;
          if (bus.num_words == '0)
            state_d = S_FINISH;
          else
            state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.abort) begin
          state_d    = S_IDLE;
          issued_d   = '0;
          sent_d     = '0;
          inflight_d = 1'b0;
          cnt_d      = 2'd0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
        end else begin
          if (rd_en)
            issued_d = issued_q + 1'b1;
          if (push)
            wr_ptr_d = ~wr_ptr_q;
          if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            sent_d   = sent_q + 1'b1;
          end
          cnt_d = cnt_q
                + {1'b0, push}
                - {1'b0, pop};
          if (pop && last_hit)
            state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entries are cleared on reset so out_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.sram_rd_data;
    end
  end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Bench for result_drain_ctrl: SRAM model, reference queue of
// expected words, directed and randomized drains.
module tb_result_drain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [159:0] sram [1024];

  result_drain_ctrl_if bus ();

  result_drain_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.sram_rd_en)
      bus.sram_rd_data <= sram[bus.sram_rd_addr];

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, 160'(bus.sram_rd_en), 160'd0);
    chk({tag, "_addr"}, 160'(bus.sram_rd_addr), 160'd0);
    chk({tag, "_valid"}, 160'(bus.out_valid), 160'd0);
    chk({tag, "_data"}, bus.out_data, 160'd0);
    chk({tag, "_last"}, 160'(bus.out_last), 160'd0);
    chk({tag, "_busy"}, 160'(bus.busy), 160'd0);
    chk({tag, "_done"}, 160'(bus.done), 160'd0);
  endtask

  // mode: 0 ready=1, 1 pattern 1,0,0,1,0,1, 2 random ready.
  task automatic run_drain(input int base, input int num,
                           input int mode, input int abort_at,
                           input bit inject, input bit ab_start);
    int c;
    int issued;
    int sent;
    int limit;
    int done_cyc;
    bit fin;
    bit ab;
    bit rdy;
    bit stall_prev;
    bit timed;
    logic [159:0] data_prev;
    logic last_prev;
    logic [159:0] exp_w;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    @(negedge clk);
    bus.start     = 1'b1;
    bus.abort     = ab_start;
    bus.base_addr = base[9:0];
    bus.num_words = num[10:0];
    bus.out_ready = 1'b1;
    @(posedge clk);
    issued = 0;
    sent = 0;
    c = 0;
    fin = 0;
    stall_prev = 0;
    data_prev = '0;
    last_prev = 1'b0;
    limit = num * 4 + 50;
    timed = (mode == 0) && (abort_at < 0);
    done_cyc = (num == 0) ? 1 : 3 + num;
    while (!fin) begin
      c++;
      @(negedge clk);
      bus.start = inject && (c == 2);
      if (inject) begin
        bus.base_addr = 10'd500;
        bus.num_words = 11'd7;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[(c - 1) % 6][0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ab = (abort_at >= 0) && (sent == abort_at);
      if (ab) rdy = 1'b0;
      bus.out_ready = rdy;
      bus.abort = ab;
      #1;
      chk("busy", 160'(bus.busy), 160'd1);
      if (timed) begin
        chk("rd_en_cyc", 160'(bus.sram_rd_en),
            160'(c <= num));
        chk("valid_cyc", 160'(bus.out_valid),
            160'(c >= 3 && c <= num + 2));
        chk("done_cyc", 160'(bus.done), 160'(c == done_cyc));
      end
      if (ab) begin
        chk("abort_rd_en", 160'(bus.sram_rd_en), 160'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        chk("abort_valid", 160'(bus.out_valid), 160'd0);
        chk("abort_busy", 160'(bus.busy), 160'd0);
        chk("abort_done", 160'(bus.done), 160'd0);
        fin = 1;
      end else begin
        if (bus.sram_rd_en) begin
          chk("rd_addr", 160'(bus.sram_rd_addr),
              160'((base + issued) % 1024));
          issued++;
        end
        if (stall_prev) begin
          chk("hold_valid", 160'(bus.out_valid), 160'd1);
          chk("hold_data", bus.out_data, data_prev);
          chk("hold_last", 160'(bus.out_last), 160'(last_prev));
        end
        if (bus.out_valid && rdy) begin
          exp_w = sram[(base + sent) % 1024];
          chk("data", bus.out_data, exp_w);
          chk("last", 160'(bus.out_last),
              160'(sent == num - 1));
          sent++;
        end
        chk("outstanding", 160'(issued - sent <= 2), 160'd1);
        chk("issued_max", 160'(issued <= num), 160'd1);
        stall_prev = bus.out_valid && !rdy;
        data_prev = bus.out_data;
        last_prev = bus.out_last;
        if (bus.done) begin
          chk("done_sent", 160'(sent), 160'(num));
          chk("done_issued", 160'(issued), 160'(num));
          @(negedge clk);
          bus.abort = 1'b0;
          #1;
          chk("post_busy", 160'(bus.busy), 160'd0);
          chk("post_done", 160'(bus.done), 160'd0);
          fin = 1;
        end else if (c > limit) begin
          chk("timeout", 160'(c), 160'(limit));
          fin = 1;
        end
      end
    end
    bus.abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      sram[i] = {$urandom, $urandom, $urandom,
                 $urandom, $urandom};
    for (int i = 0; i < 4; i++)
      sram[i] = 160'(8'hA0 + i);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.out_ready = 1'b0;
    bus.sram_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("reset");

    // abort while idle is ignored
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("idle_abort_busy", 160'(bus.busy), 160'd0);

    run_drain(0, 4, 0, -1, 0, 0);
    run_drain(10, 3, 1, -1, 0, 0);
    run_drain(1022, 3, 0, -1, 0, 0);
    run_drain(50, 0, 0, -1, 0, 0);
    run_drain(40, 8, 0, 2, 0, 0);
    run_drain(16, 1, 0, -1, 0, 0);

    // reset during a stall with the buffer full
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 10'd100;
    bus.num_words = 11'd4;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("full_valid", 160'(bus.out_valid), 160'd1);
    chk("full_data", bus.out_data, sram[100]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    run_drain(0, 4, 0, -1, 0, 0);

    run_drain(200, 5, 0, -1, 1, 0);
    run_drain(7, 2, 0, -1, 0, 1);

    for (int k = 0; k < 6; k++)
      run_drain($urandom_range(0, 1023),
                $urandom_range(1, 20), 2, -1, 0, 0);
    run_drain(5, 1024, 2, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
